// File: rtl/exu_mc_if.sv
// exu_mc_if: valid/ready bundle carrying one op into exu_mc and its result out
//   master : upstream/downstream side (IDU drives the op, LSU/WBU drives out_ready)
//   slave  : exu_mc side
//   issue  : in_valid/in_ready, alu_op, md_en, md_op, rs1, rs2, pc, imm, alu_sel_left, alu_sel_right
//   result : out_valid/out_ready, result, zero_flag
interface exu_mc_if #(parameter int WIDTH = 32);
    logic in_valid, in_ready, md_en, alu_sel_left, out_valid, out_ready, zero_flag;
    logic [3:0] alu_op;
    logic [2:0] md_op;
    logic [1:0] alu_sel_right;
    logic [WIDTH-1:0] rs1, rs2, pc, imm, result;
    modport master(
        output in_valid, alu_op, md_en, md_op, rs1, rs2, pc, imm, alu_sel_left, alu_sel_right, out_ready,
        input in_ready, out_valid, result, zero_flag
    );
    modport slave(
        input in_valid, alu_op, md_en, md_op, rs1, rs2, pc, imm, alu_sel_left, alu_sel_right, out_ready,
        output in_ready, out_valid, result, zero_flag
    );
endinterface

// File: rtl/exu_mc.sv
// exu_mc: multi-cycle execute unit, ALU in one cycle plus iterative RV32M mul/div
//   clk, rst : clock, asynchronous active-high reset
//   flush    : synchronous kill of the in-flight op
//   busy     : state != IDLE
//   bus      : exu_mc_if.slave, op in / registered result out
// ALU encoding (alu_op): 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu,
//   0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and; anything else adds.
module exu_mc #(
    parameter int WIDTH = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    output logic busy,
    exu_mc_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(WIDTH);
    localparam int DW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0] op;
    logic neg, sa, sb, neg_in, dz, ovf, one, acc, last;
    logic [WIDTH-1:0] hi, lo, dvs, hi_n, lo_n, left, right, alu, ma, mb, q, fin, quick, res_n;
    logic [WIDTH:0] madd, rem_sh, dif;
    logic [DW-1:0] fp, fpn, pn;
    assign bus.in_ready = state == IDLE || (state == DONE && bus.out_ready);
    assign bus.out_valid = state == DONE;
    assign busy = state != IDLE;
    assign acc = bus.in_valid && bus.in_ready && !flush;
    assign last = state == CALC && cnt == CW'(1) && !flush;
    always_comb begin
        left = bus.alu_sel_left ? bus.pc : bus.rs1;
        right = bus.alu_sel_right == 2'b00 ? bus.rs2 : bus.alu_sel_right == 2'b10 ? WIDTH'(4) : bus.imm;
        alu = left + right;
        case (bus.alu_op)
            4'b1000: alu = left - right;
            4'b0001: alu = left << right[SW-1:0];
            4'b0010: alu = WIDTH'($signed(left) < $signed(right));
            4'b0011: alu = WIDTH'(left < right);
            4'b0100: alu = left ^ right;
            4'b0101: alu = left >> right[SW-1:0];
            4'b1101: alu = $signed(left) >>> right[SW-1:0];
            4'b0110: alu = left | right;
            4'b0111: alu = left & right;
            default: alu = left + right;
        endcase
    end
    // Operand magnitudes and the sign the final result needs (REM follows the dividend).
    always_comb begin
        sa = bus.rs1[WIDTH-1] && (bus.md_op == 3'd1 || bus.md_op == 3'd2 || (bus.md_op[2] && !bus.md_op[0]));
        sb = bus.rs2[WIDTH-1] && (bus.md_op == 3'd1 || (bus.md_op[2] && !bus.md_op[0]));
        neg_in = bus.md_op == 3'd6 ? sa : sa ^ sb;
        ma = sa ? -bus.rs1 : bus.rs1;
        mb = sb ? -bus.rs2 : bus.rs2;
        dz = bus.rs2 == '0;
        ovf = !bus.md_op[0] && bus.rs1 == MIN && &bus.rs2;
        fp = DW'(ma) * DW'(mb);
        fpn = neg_in ? -fp : fp;
        one = !bus.md_en || (bus.md_op[2] ? dz || ovf : FAST_MUL);
        quick = !bus.md_en ? alu
              : !bus.md_op[2] ? (bus.md_op[1:0] == 2'd0 ? fpn[WIDTH-1:0] : fpn[DW-1:WIDTH])
              : dz ? (bus.md_op[1] ? bus.rs1 : '1)
              : (bus.md_op[1] ? '0 : MIN);
    end
    // One radix-2 step: shift-add multiply on {hi,lo}, or restoring divide with
    // hi as partial remainder and lo shifting dividend bits out / quotient bits in.
    always_comb begin
        madd = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        rem_sh = {hi, lo[WIDTH-1]};
        dif = rem_sh - {1'b0, dvs};
        hi_n = op[2] ? (dif[WIDTH] ? rem_sh[WIDTH-1:0] : dif[WIDTH-1:0]) : madd[WIDTH:1];
        lo_n = op[2] ? {lo[WIDTH-2:0], !dif[WIDTH]} : {madd[0], lo[WIDTH-1:1]};
        pn = neg ? -{hi_n, lo_n} : {hi_n, lo_n};
        q = op[1] ? hi_n : lo_n;
        fin = op[2] ? (neg ? -q : q) : (op[1:0] == 2'd0 ? pn[WIDTH-1:0] : pn[DW-1:WIDTH]);
        res_n = last ? fin : quick;
    end
    always_comb begin
        state_n = state;
        if (flush) state_n = IDLE;
        else if (acc) state_n = one ? DONE : CALC;
        else if (last) state_n = DONE;
        else if (state == DONE && bus.out_ready) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.result <= '0;
            bus.zero_flag <= 1'b0;
            cnt <= '0;
            op <= '0;
            neg <= 1'b0;
            hi <= '0;
            lo <= '0;
            dvs <= '0;
        end else begin
            if ((acc && one) || last) begin
                bus.result <= res_n;
                bus.zero_flag <= res_n == '0;
            end
            if (acc) begin
                op <= bus.md_op;
                neg <= neg_in;
                hi <= '0;
                lo <= bus.md_op[2] ? ma : mb;
                dvs <= bus.md_op[2] ? mb : ma;
                cnt <= one ? '0 : CW'(WIDTH);
            end else if (state == CALC) begin
                hi <= hi_n;
                lo <= lo_n;
                cnt <= flush ? '0 : cnt - 1'b1;
            end
        end
endmodule

// File: tb/tb_exu_mc.sv
// tb_exu_mc: randomized and directed check of exu_mc against a 64-bit arithmetic reference
module tb_exu_mc;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, busy;
    int total = 0, bad = 0;
    logic [3:0] aops [10] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'h6, 4'h7};
    exu_mc_if #(.WIDTH(32)) bus();
    exu_mc #(.WIDTH(32), .FAST_MUL(1'b0)) dut(.clk(clk), .rst(rst), .flush(flush), .busy(busy), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] l, input logic [31:0] r);
        case (op)
            4'h8: return l - r;
            4'h1: return l << r[4:0];
            4'h2: return {31'b0, $signed(l) < $signed(r)};
            4'h3: return {31'b0, l < r};
            4'h4: return l ^ r;
            4'h5: return l >> r[4:0];
            4'hD: return $signed(l) >>> r[4:0];
            4'h6: return l | r;
            4'h7: return l & r;
            default: return l + r;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic ovf;
        int ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            3'd1: p = longint'(ia) * longint'(ib);
            3'd2: p = longint'(ia) * longint'({32'b0, b});
            default: p = {32'b0, a} * {32'b0, b};
        endcase
        case (op)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    task automatic drive(input logic en, input logic [3:0] aop, input logic [2:0] mop, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                         input logic sl, input logic [1:0] sr);
        bus.md_en = en;
        bus.alu_op = aop;
        bus.md_op = mop;
        bus.rs1 = a;
        bus.rs2 = b;
        bus.pc = p;
        bus.imm = im;
        bus.alu_sel_left = sl;
        bus.alu_sel_right = sr;
        bus.in_valid = 1'b1;
    endtask

    task automatic scramble();
        bus.in_valid = 1'b0;
        bus.md_en = 1'($urandom);
        bus.alu_op = 4'($urandom);
        bus.md_op = 3'($urandom);
        bus.rs1 = $urandom;
        bus.rs2 = $urandom;
        bus.pc = $urandom;
        bus.imm = $urandom;
        bus.alu_sel_left = 1'($urandom);
        bus.alu_sel_right = 2'($urandom);
    endtask

    // Issues one op from IDLE, checks latency/result/flag, then lets it drain to IDLE.
    task automatic run_op(input logic en, input logic [3:0] aop, input logic [2:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p, input logic [31:0] im,
                          input logic sl, input logic [1:0] sr, output logic [31:0] got);
        logic [31:0] exp, l, r;
        int lat, n;
        l = sl ? p : a;
        r = sr == 2'b00 ? b : sr == 2'b10 ? 32'd4 : im;
        exp = en ? ref_md(mop, a, b) : ref_alu(aop, l, r);
        lat = (!en || (mop[2] && (b == 0 || (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))) ? 0 : 32;
        drive(en, aop, mop, a, b, p, im, sl, sr);
        @(posedge clk);
        #1;
        scramble();
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("result", bus.result, exp);
        chk("zero_flag", bus.zero_flag, exp == 0);
        got = bus.result;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] got, prev;
        bit seen;
        scramble();
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_zf", bus.zero_flag, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("rst_ready", bus.in_ready, 1);

        run_op(1'b0, 4'h0, 3'd0, 32'h0, 32'h0, 32'h8000_0000, 32'h0, 1'b1, 2'b10, got);
        chk("t1_pc4", got, 32'h8000_0004);
        run_op(1'b1, 4'h0, 3'd0, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t2_mul", got, 32'hFFFF_FFFD);
        run_op(1'b1, 4'h0, 3'd1, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t2_mulh", got, 32'hFFFF_FFFF);
        run_op(1'b1, 4'h0, 3'd3, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t2_mulhu", got, 32'h2);
        run_op(1'b1, 4'h0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t3_div", got, 32'hFFFF_FFFD);
        run_op(1'b1, 4'h0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t3_rem", got, 32'hFFFF_FFFF);
        run_op(1'b1, 4'h0, 3'd5, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t3_divu", got, 32'd14);
        run_op(1'b1, 4'h0, 3'd7, 32'd100, 32'd7, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t3_remu", got, 32'd2);
        run_op(1'b1, 4'h0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t4_div_ovf", got, 32'h8000_0000);
        run_op(1'b1, 4'h0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t4_rem_ovf", got, 32'h0);
        run_op(1'b1, 4'h0, 3'd5, 32'd7, 32'd0, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t4_divu_z", got, 32'hFFFF_FFFF);
        run_op(1'b1, 4'h0, 3'd7, 32'd7, 32'd0, 32'h0, 32'h0, 1'b0, 2'b00, got);
        chk("t4_remu_z", got, 32'd7);

        bus.out_ready = 1'b0;
        drive(1'b0, 4'h0, 3'd0, 32'd5, 32'd7, 32'h0, 32'h0, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        scramble();
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_result", bus.result, 32'd12);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold", bus.result, 32'd12);
            chk("bp_ready", bus.in_ready, 0);
        end
        drive(1'b0, 4'h8, 3'd0, 32'd100, 32'd1, 32'h0, 32'h0, 1'b0, 2'b00);
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        scramble();
        chk("b2b_valid", bus.out_valid, 1);
        chk("b2b_result", bus.result, 32'd99);
        @(posedge clk);
        #1;
        chk("b2b_idle", busy, 0);

        prev = bus.result;
        drive(1'b1, 4'h0, 3'd4, 32'd1000, 32'd3, 32'h0, 32'h0, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        scramble();
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("fl_busy", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_ready", bus.in_ready, 1);
        chk("fl_result", bus.result, prev);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("fl_never_valid", seen, 0);
        drive(1'b0, 4'h0, 3'd0, 32'd1, 32'd1, 32'h0, 32'h0, 1'b0, 2'b00);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        scramble();
        chk("fl_beats_acc", busy, 0);
        chk("fl_acc_result", bus.result, prev);

        drive(1'b1, 4'h0, 3'd0, 32'd7, 32'd9, 32'h0, 32'h0, 1'b0, 2'b00);
        @(posedge clk);
        #1;
        scramble();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_result", bus.result, 0);
        chk("rst_mid_zf", bus.zero_flag, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        for (int i = 0; i < 250; i++) begin
            logic en;
            en = $urandom_range(0, 2) != 0;
            run_op(en, aops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), pick(), pick(), $urandom, $urandom,
                   1'($urandom), 2'($urandom), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
